// File: rtl/alu_demux_pkg.sv
// Shared constants and lane-select encoding for the 1:4 word demultiplexer.
// Select decoding is the inverse of the 4:1 mux encoding used elsewhere.
package alu_demux_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned NUM_LANES     = 4;
    localparam int unsigned COUNT_W       = 16;

    typedef enum logic [1:0] {
        SEL_LANE0 = 2'b00,
        SEL_LANE1 = 2'b01,
        SEL_LANE2 = 2'b10,
        SEL_LANE3 = 2'b11
    } lane_sel_e;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_sel_e sel);
        return NUM_LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/alu_demux_lane.sv
// One demux lane: single-entry holding register, full flag and accept counter.
module alu_demux_lane
    import alu_demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               ready,
    output logic [WIDTH-1:0]   data,
    output logic               full,
    output logic [COUNT_W-1:0] count
);

    // A load wins over a same-cycle drain so the replacing word is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            data  <= load_data;
            count <= count + COUNT_W'(1);
        end else if (full && ready) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_demux4.sv
// 1:4 demultiplexer routing a valid/ready word stream into four registered lanes.
// Only select decode and the in_ready mux live here; all state is in the lanes.
module alu_demux4
    import alu_demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 select2,
    input  logic                 select1,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [COUNT_W-1:0]   lane_count0,
    output logic [COUNT_W-1:0]   lane_count1,
    output logic [COUNT_W-1:0]   lane_count2,
    output logic [COUNT_W-1:0]   lane_count3
);

    lane_sel_e            sel;
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] load;
    logic [WIDTH-1:0]     lane_data  [NUM_LANES];
    logic [COUNT_W-1:0]   lane_count [NUM_LANES];

    assign sel = lane_sel_e'({select2, select1});

    always_comb begin
        in_ready = 1'b0;
        load     = '0;
        if (!reset && !flush) begin
            in_ready = !full[sel] || out_ready[sel];
        end
        if (in_valid && in_ready) begin
            load = lane_onehot(sel);
        end
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        alu_demux_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .load     (load[n]),
            .load_data(in_data),
            .ready    (out_ready[n]),
            .data     (lane_data[n]),
            .full     (full[n]),
            .count    (lane_count[n])
        );
    end

    assign out_valid   = full;
    assign out_data0   = lane_data[0];
    assign out_data1   = lane_data[1];
    assign out_data2   = lane_data[2];
    assign out_data3   = lane_data[3];
    assign lane_count0 = lane_count[0];
    assign lane_count1 = lane_count[1];
    assign lane_count2 = lane_count[2];
    assign lane_count3 = lane_count[3];

endmodule

// File: tb/tb_alu_demux4.sv
// Scoreboard bench for alu_demux4: directed vectors plus a randomised traffic phase.
module tb_alu_demux4;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, flush, select2, select1, in_valid, in_ready;
    logic [W-1:0] in_data, out_data0, out_data1, out_data2, out_data3;
    logic [3:0]   out_valid, out_ready;
    logic [15:0]  lane_count0, lane_count1, lane_count2, lane_count3;

    logic [W-1:0] exp_q [4][$];
    logic [15:0]  cnt_model [4];
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    alu_demux4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_data    (in_data),
        .select2    (select2),
        .select1    (select1),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .lane_count0(lane_count0),
        .lane_count1(lane_count1),
        .lane_count2(lane_count2),
        .lane_count3(lane_count3)
    );

    function automatic logic [W-1:0] lane_data(input int n);
        case (n)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    function automatic logic [15:0] lane_cnt(input int n);
        case (n)
            0:       return lane_count0;
            1:       return lane_count1;
            2:       return lane_count2;
            default: return lane_count3;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; the word is recorded as expected when the model says it is accepted.
    task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                        input logic [3:0] ordy, input logic fl, input logic rst);
        logic exp_rdy;
        in_valid  = v;
        {select2, select1} = s;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        exp_rdy = !rst && !fl && (exp_q[s].size() == 0 || ordy[s]);
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        if (v && exp_rdy) begin
            exp_q[s].push_back(d);
            cnt_model[s] = cnt_model[s] + 16'd1;
        end
        if (rst) begin
            for (int n = 0; n < 4; n++) cnt_model[n] = '0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every drain handshake must deliver the oldest expected word of that lane.
    always @(negedge clk) begin
        if (reset || flush) begin
            for (int n = 0; n < 4; n++) exp_q[n].delete();
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (out_valid[n] && out_ready[n]) begin
                    if (exp_q[n].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL lane%0d_spurious: got 0x%0h expected no word", n, lane_data(n));
                    end else begin
                        check($sformatf("lane%0d_data", n), {32'd0, lane_data(n)}, {32'd0, exp_q[n].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; select2 = 1'b0; select1 = 1'b0;
        in_data = '0; out_ready = '0;
        for (int n = 0; n < 4; n++) cnt_model[n] = '0;
        @(posedge clk);
        #1;
        step(1'b0, 2'b00, '0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 2'b00, '0, 4'h0, 1'b0, 1'b1);
        check("rst_valid", {60'd0, out_valid}, 64'h0);
        for (int n = 0; n < 4; n++) begin
            check($sformatf("rst_count%0d", n), {48'd0, lane_cnt(n)}, 64'h0);
            check($sformatf("rst_data%0d", n), {32'd0, lane_data(n)}, 64'h0);
        end

        // Single word into lane 2
        step(1'b1, 2'b10, 32'h0000_00A5, 4'h0, 1'b0, 1'b0);
        check("l2_valid", {60'd0, out_valid}, 64'h4);
        check("l2_data", {32'd0, out_data2}, 64'hA5);
        check("l2_count", {48'd0, lane_count2}, 64'h1);

        // Full lane 1 back-pressures, then drain and reload on the same edge
        step(1'b1, 2'b01, 32'h1111_1111, 4'h0, 1'b0, 1'b0);
        check("l1_valid", {60'd0, out_valid}, 64'h6);
        step(1'b1, 2'b01, 32'h2222_2222, 4'h0, 1'b0, 1'b0);
        check("l1_hold_data", {32'd0, out_data1}, 64'h1111_1111);
        check("l1_hold_count", {48'd0, lane_count1}, 64'h1);
        step(1'b1, 2'b01, 32'h1234_5678, 4'h2, 1'b0, 1'b0);
        check("l1_replace_valid", {60'd0, out_valid}, 64'h6);
        check("l1_replace_data", {32'd0, out_data1}, 64'h1234_5678);
        check("l1_replace_count", {48'd0, lane_count1}, 64'h2);

        // Fill every lane, then flush with a word presented
        step(1'b1, 2'b00, 32'h0000_00C0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 2'b11, 32'h0000_00D3, 4'h0, 1'b0, 1'b0);
        check("all_full", {60'd0, out_valid}, 64'hF);
        step(1'b1, 2'b00, 32'h0000_00EE, 4'h0, 1'b1, 1'b0);
        check("flush_valid", {60'd0, out_valid}, 64'h0);
        check("flush_count0", {48'd0, lane_count0}, 64'h1);
        check("flush_count1", {48'd0, lane_count1}, 64'h2);
        check("flush_count2", {48'd0, lane_count2}, 64'h1);
        check("flush_count3", {48'd0, lane_count3}, 64'h1);

        // Reset wins over a presented word into lane 0
        step(1'b1, 2'b00, 32'h0000_0077, 4'h0, 1'b0, 1'b0);
        check("pre_rst_count0", {48'd0, lane_count0}, 64'h2);
        step(1'b1, 2'b00, 32'h0000_0099, 4'h0, 1'b0, 1'b1);
        check("mid_rst_valid", {60'd0, out_valid}, 64'h0);
        check("mid_rst_count0", {48'd0, lane_count0}, 64'h0);
        check("mid_rst_data0", {32'd0, out_data0}, 64'h0);

        // Counter wrap on lane 3
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 2'b11, W'(i) ^ 32'h5A00_0000, 4'h8, 1'b0, 1'b0);
            if (i == 65534) check("wrap_pre", {48'd0, lane_count3}, 64'hFFFF);
        end
        check("wrap_count3", {48'd0, lane_count3}, 64'h0);
        check("wrap_count0", {48'd0, lane_count0}, 64'h0);
        check("wrap_count1", {48'd0, lane_count1}, 64'h0);
        check("wrap_count2", {48'd0, lane_count2}, 64'h0);
        step(1'b0, 2'b00, '0, 4'hF, 1'b0, 1'b0);
        check("wrap_drained", {60'd0, out_valid}, 64'h0);

        // Random traffic with occasional flush
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0), 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, '0, 4'hF, 1'b0, 1'b0);
        check("final_valid", {60'd0, out_valid}, 64'h0);
        for (int n = 0; n < 4; n++) begin
            check($sformatf("lane%0d_leftover", n), 64'(exp_q[n].size()), 64'h0);
            check($sformatf("final_count%0d", n), {48'd0, lane_cnt(n)}, {48'd0, cnt_model[n]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_demux4.md
ALU_DEMUX4 -- requirements
Module: alu_demux4

Interface
REQ-001 Parameter: WIDTH, default 32, data width of input word and each output lane.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset is synchronous and active-high.
REQ-004 Port: flush  input  1  synchronous clear of all lane contents, excluding counters.
REQ-005 Port: in_data  input  WIDTH  word to be routed.
REQ-006 Port: select2  input  1  lane select MSB; lane = {select2, select1}.
REQ-007 Port: select1  input  1  lane select LSB.
REQ-008 Port: in_valid  input  1  in_data and select valid this cycle.
REQ-009 Port: in_ready  output  1  block accepts the word this cycle.
REQ-010 Port: out_data0..out_data3  output  WIDTH each  registered lane data.
REQ-011 Port: out_valid  output  4  bit n: lane n holds a word.
REQ-012 Port: out_ready  input  4  bit n: lane n consumer takes the word.
REQ-013 Port: lane_count0..lane_count3  output  16 each  words accepted into lane n since reset.

Function
REQ-014 Routing SHALL be 00->lane0, 01->lane1, 10->lane2, 11->lane3, the inverse of the team's 4:1 mux select encoding.
REQ-015 Each lane SHALL be a one-entry holding register with a full flag; out_valid[n] = full[n].
REQ-016 in_ready SHALL be combinational: !full[sel] || out_ready[sel], with sel = {select2, select1}, and 0 while reset or flush is high.
REQ-017 Accept = in_valid && in_ready; on accept, lane sel SHALL load in_data and set full on the next edge (latency 1 cycle).
REQ-018 Lane n drain = full[n] && out_ready[n]; on drain without a same-cycle load, full[n] SHALL clear on the next edge.
REQ-019 Simultaneous drain and load of the same lane SHALL replace the data, keep full set, and lose no word.
REQ-020 Lanes not selected SHALL hold data and full unchanged except for their own drain.
REQ-021 out_data[n] SHALL hold its value while full[n] is set and out_ready[n] is low; the value when empty is don't-care.
REQ-022 lane_count[n] SHALL increment by 1 on each accept into lane n and wrap from 0xFFFF to 0x0000.
REQ-023 flush SHALL clear all full flags on the next edge, block accepts that cycle, and leave counters unchanged.
REQ-024 in_valid with select inputs changing while in_ready is low SHALL NOT be an error; no state is held for unaccepted words.

Reset
REQ-025 On reset, all full flags, all out_data registers, and all lane_count outputs SHALL go to 0 on the next edge.
REQ-026 Reset SHALL take priority over flush, accept, and drain in the same cycle; a word presented during reset SHALL be discarded.
REQ-027 Reset asserted mid-operation SHALL drop every held word with no partial lane state retained.

Structure
REQ-028 Package alu_demux_pkg SHALL hold WIDTH default, NUM_LANES=4, COUNT_W=16, and the lane-select encoding constants.
REQ-029 Sub-module alu_demux_lane SHALL implement one lane (data register, full flag, counter) and be instantiated four times.
REQ-030 Top level SHALL contain only select decode, in_ready mux, and lane instances.

Verification
REQ-031 Reset, then send 0x0000_00A5 with select=10 and all out_ready=0 -> next cycle out_valid=0100, out_data2=0x0000_00A5, lane_count2=1.
REQ-032 Lane1 full with out_ready[1]=0, send with select=01 -> in_ready=0; raise out_ready[1] with a new word 0x1234_5678 -> same edge drains the old word and loads the new one, out_valid[1] stays 1.
REQ-033 Send 65536 words to lane3 with out_ready[3]=1 -> lane_count3 wraps to 0x0000; other counters stay 0.
REQ-034 Fill all four lanes, assert flush with in_valid=1 -> in_ready=0 and out_valid=0000 next cycle; counters unchanged.
REQ-035 Assert reset in the same cycle as an accept into lane0 -> out_valid=0000, lane_count0=0, out_data0=0 after the edge.
REQ-036 Random select, in_valid, and out_ready for 10k cycles -> scoreboard shows per-lane in-order delivery with no loss or duplication.
